avoid_collision_ctrl: RTL and testbench
=======================================

Name: avoid_collision_ctrl

Overview:
Game-state controller directly downstream of the avoiding-ball mover. It consumes the ball bounding box and the player bounding box, detects contact once per video frame, and manages lives, score and pause. It drives game_stop and en back into the ball mover. 640x480 raster; x/y come from the VGA sync counters.

Parameters:
MAX_X, 640, horizontal active pixels (frame tick at x==MAX_X-1)
MAX_Y, 480, vertical active lines (frame tick at y==MAX_Y-1)
LIVES, 3, lives loaded at reset and at game start (1..3)
HIT_FRAMES, 60, frames spent in HIT before leaving it
SCORE_DIV, 60, PLAY frames per score increment

Ports:
clk  in  1  pixel clock
rst  in  1  reset, asynchronous, active-high
x  in  10  current pixel column
y  in  10  current pixel line
key  in  5  buttons, active-high, synchronous to clk; key[4]=start, key[3]=pause
ball_x_l, ball_x_r, ball_y_t, ball_y_b  in  10 each  ball box, inclusive edges
ply_x_l, ply_x_r, ply_y_t, ply_y_b  in  10 each  player box, inclusive edges
game_stop  out  1  1 = ball held at centre, velocity reset
en  out  1  1 = ball may move on frame tick
lives  out  2  remaining lives
score  out  8  survival score, saturating
hit_pulse  out  1  one-cycle pulse on each contact
state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, game_stop=1, en=0, lives=LIVES, score=0, hit_pulse=0. Frame counter=0, start/pause edge registers=0.
- frame_tick = (x==MAX_X-1 && y==MAX_Y-1); it is high for exactly one clk per frame.
- start_edge = key[4] & ~key4_d, where key4_d is key[4] registered. Holding the key produces one edge only.
- overlap = (ball_x_l<=ply_x_r)&(ball_x_r>=ply_x_l)&(ball_y_t<=ply_y_b)&(ball_y_b>=ply_y_t). Comparisons are unsigned. Touching edges count as overlap.
- IDLE:
  - game_stop=1, en=0.
  - On start_edge: go to PLAY; load lives=LIVES; clear score and frame counter.
- PLAY:
  - game_stop=0, en=1.
  - Overlap is sampled only on frame_tick.
  - frame_tick & overlap: hit_pulse=1 for the next cycle; lives decrements by 1 that cycle; frame counter clears.
    - If lives was 1 before the decrement: go to OVER.
    - Otherwise: go to HIT.
  - frame_tick & !overlap: frame counter increments. When it reaches SCORE_DIV-1, it clears and score increments. Score saturates at 255.
  - Contact takes priority over scoring in the same tick.
- HIT:
  - game_stop=1, en=0, so the ball recentres.
  - Frame counter increments per frame_tick. At HIT_FRAMES-1 it clears and the block returns to PLAY.
  - start_edge is ignored.
- OVER:
  - game_stop=1, en=0; lives=0; score holds.
  - On start_edge: go to PLAY, reloading lives, score and frame counter as from IDLE.
- Latency: state, game_stop and en change one clk after the qualifying frame_tick or start_edge.
- Lives never underflow. Score never wraps.
- Reset asserted mid-game returns every register to its reset value immediately (asynchronous).

Optional Feature:
Macro AVOID_PAUSE_EN.
- Defined:
  - key[3] rising edge in PLAY enters PAUSE (state encoding 3 is shared with OVER, distinguished by an internal paused flag). Outputs in PAUSE: game_stop=0, en=0, so the ball freezes in place.
  - In PAUSE: no contact check, no scoring, frame counter holds.
  - Next key[3] rising edge returns to PLAY.
  - key[3] in any other state is ignored.
- Not defined: key[3] is ignored and the block has no pause logic.

Test Plan:
1. Reset, then key[4] pulse -> state=1, game_stop=0, en=0->1 next clk, lives=3, score=0.
2. PLAY, no overlap, 120 frame ticks -> score=2, lives=3, hit_pulse never high.
3. PLAY, ball box 100..119 and player box 119..140 on both axes, one frame tick -> hit_pulse one cycle, lives=2, state=2, game_stop=1. After 60 ticks -> state=1.
4. Three contacts -> lives=0, state=3. key[4] held high for 10 clk -> exactly one restart, lives=3, score=0.
5. Score preloaded near max, 60*300 clean frames -> score stays 255. Contact and score boundary on the same tick -> lives decrements, score unchanged.
6. AVOID_PAUSE_EN: key[3] edge in PLAY -> en=0, game_stop=0. Overlap plus 200 ticks -> no hit, score constant. Second key[3] edge -> en=1. Assert rst mid-PAUSE -> state=0 at once.

Source files
------------

// File: rtl/avoid_collision_ctrl_if.sv
// -----------------------------------------------------------------------------
// avoid_collision_ctrl_if
// Bundles the signals exchanged between the game-state controller and its
// surroundings: raster position, buttons, the ball and player bounding boxes,
// and the controller's outputs back to the ball mover and display.
//
// Signals:
//   x, y            raster column/line from the VGA sync counters (10 bit)
//   key             buttons, active-high, key[4]=start, key[3]=pause
//   ball_*          ball bounding box, inclusive edges
//   ply_*           player bounding box, inclusive edges
//   game_stop       1 = ball held at centre with velocity reset
//   en              1 = ball may move on the frame tick
//   lives           remaining lives
//   score           survival score, saturating at 255
//   hit_pulse       one-cycle pulse per contact
//   state           IDLE=0, PLAY=1, HIT=2, OVER/PAUSE=3
//
// Modports:
//   master  drives raster/buttons/boxes, observes controller outputs
//   slave   the controller itself
// -----------------------------------------------------------------------------
interface avoid_collision_ctrl_if;
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] key;
    logic [9:0] ball_x_l;
    logic [9:0] ball_x_r;
    logic [9:0] ball_y_t;
    logic [9:0] ball_y_b;
    logic [9:0] ply_x_l;
    logic [9:0] ply_x_r;
    logic [9:0] ply_y_t;
    logic [9:0] ply_y_b;
    logic       game_stop;
    logic       en;
    logic [1:0] lives;
    logic [7:0] score;
    logic       hit_pulse;
    logic [1:0] state;

    modport master (
        output x, y, key,
        output ball_x_l, ball_x_r, ball_y_t, ball_y_b,
        output ply_x_l, ply_x_r, ply_y_t, ply_y_b,
        input  game_stop, en, lives, score, hit_pulse, state
    );

    modport slave (
        input  x, y, key,
        input  ball_x_l, ball_x_r, ball_y_t, ball_y_b,
        input  ply_x_l, ply_x_r, ply_y_t, ply_y_b,
        output game_stop, en, lives, score, hit_pulse, state
    );
endinterface

// File: rtl/avoid_collision_ctrl.sv
// -----------------------------------------------------------------------------
// avoid_collision_ctrl
// Game-state controller sitting downstream of the avoiding-ball mover. Once per
// video frame it checks whether the ball box touches the player box, and it
// manages lives, the survival score and (optionally) pause. game_stop and en
// are fed back into the ball mover.
//
// Ports:
//   clk   pixel clock
//   rst   asynchronous, active-high reset
//   bus   avoid_collision_ctrl_if.slave (raster, keys, boxes, outputs)
//
// Optional feature:
//   AVOID_PAUSE_EN  when defined, a key[3] rising edge in PLAY freezes the
//                   ball (state reads 3, game_stop=0, en=0); the next key[3]
//                   edge resumes play. When undefined key[3] is ignored.
// -----------------------------------------------------------------------------
module avoid_collision_ctrl #(
    parameter int MAX_X      = 640,
    parameter int MAX_Y      = 480,
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 60,
    parameter int SCORE_DIV  = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    avoid_collision_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam logic [9:0]  X_LAST     = 10'(MAX_X - 1);
    localparam logic [9:0]  Y_LAST     = 10'(MAX_Y - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [15:0] HIT_LAST   = 16'(HIT_FRAMES - 1);
    localparam logic [15:0] SCORE_LAST = 16'(SCORE_DIV - 1);

    // Inclusive-edge box intersection; touching edges count as contact.
    function automatic logic box_overlap(
        input logic [9:0] a_l, input logic [9:0] a_r,
        input logic [9:0] a_t, input logic [9:0] a_b,
        input logic [9:0] b_l, input logic [9:0] b_r,
        input logic [9:0] b_t, input logic [9:0] b_b
    );
        box_overlap = (a_l <= b_r) & (a_r >= b_l) & (a_t <= b_b) & (a_b >= b_t);
    endfunction

    // Saturating score increment so the score never wraps.
    function automatic logic [7:0] score_inc(input logic [7:0] s);
        score_inc = (s == 8'hFF) ? s : (s + 8'd1);
    endfunction

    state_t      state_r;
    state_t      state_n;
    logic [15:0] frame_cnt_r;
    logic [15:0] frame_cnt_n;
    logic [1:0]  lives_r;
    logic [1:0]  lives_n;
    logic [7:0]  score_r;
    logic [7:0]  score_n;
    logic        hit_pulse_r;
    logic        hit_pulse_n;
    logic        game_stop_r;
    logic        game_stop_n;
    logic        en_r;
    logic        en_n;
    logic        key4_d_r;
    logic        frame_tick_s;
    logic        overlap_s;
    logic        start_edge_s;
    logic        unused_key_s;

`ifdef AVOID_PAUSE_EN
    logic        key3_d_r;
    logic        pause_edge_s;
    logic        paused_r;
    logic        paused_n;
`endif

    assign frame_tick_s = (bus.x == X_LAST) && (bus.y == Y_LAST);
    assign start_edge_s = bus.key[4] & ~key4_d_r;
    assign overlap_s    = box_overlap(bus.ball_x_l, bus.ball_x_r, bus.ball_y_t, bus.ball_y_b,
                                      bus.ply_x_l,  bus.ply_x_r,  bus.ply_y_t,  bus.ply_y_b);

`ifdef AVOID_PAUSE_EN
    assign pause_edge_s = bus.key[3] & ~key3_d_r;
    assign unused_key_s = ^bus.key[2:0];
`else
    assign unused_key_s = ^bus.key[3:0];
`endif

    // Next-state, counter, lives/score and output decode.
    always_comb begin
        state_n     = state_r;
        frame_cnt_n = frame_cnt_r;
        lives_n     = lives_r;
        score_n     = score_r;
        hit_pulse_n = 1'b0;
        game_stop_n = 1'b1;
        en_n        = 1'b0;
`ifdef AVOID_PAUSE_EN
        paused_n    = paused_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_n     = ST_PLAY;
                    lives_n     = LIVES_INIT;
                    score_n     = 8'd0;
                    frame_cnt_n = 16'd0;
                end else begin
                    state_n     = ST_IDLE;
                end
            end

            ST_PLAY: begin
`ifdef AVOID_PAUSE_EN
                // A pause request wins over a coincident frame tick.
                if (pause_edge_s) begin
                    state_n  = ST_OVER;
                    paused_n = 1'b1;
                end else
`endif
                if (frame_tick_s) begin
                    if (overlap_s) begin
                        // Contact beats scoring on the same tick.
                        hit_pulse_n = 1'b1;
                        frame_cnt_n = 16'd0;
                        if (lives_r <= 2'd1) begin
                            lives_n = 2'd0;
                            state_n = ST_OVER;
                        end else begin
                            lives_n = lives_r - 2'd1;
                            state_n = ST_HIT;
                        end
                    end else if (frame_cnt_r >= SCORE_LAST) begin
                        frame_cnt_n = 16'd0;
                        score_n     = score_inc(score_r);
                    end else begin
                        frame_cnt_n = frame_cnt_r + 16'd1;
                    end
                end else begin
                    state_n = ST_PLAY;
                end
            end

            ST_HIT: begin
                // Recovery period; start presses and contact are not looked at.
                if (frame_tick_s) begin
                    if (frame_cnt_r >= HIT_LAST) begin
                        frame_cnt_n = 16'd0;
                        state_n     = ST_PLAY;
                    end else begin
                        frame_cnt_n = frame_cnt_r + 16'd1;
                    end
                end else begin
                    state_n = ST_HIT;
                end
            end

            ST_OVER: begin
`ifdef AVOID_PAUSE_EN
                // Encoding 3 doubles as PAUSE; the flag tells them apart.
                if (paused_r) begin
                    if (pause_edge_s) begin
                        state_n  = ST_PLAY;
                        paused_n = 1'b0;
                    end else begin
                        state_n  = ST_OVER;
                    end
                end else
`endif
                if (start_edge_s) begin
                    state_n     = ST_PLAY;
                    lives_n     = LIVES_INIT;
                    score_n     = 8'd0;
                    frame_cnt_n = 16'd0;
                end else begin
                    lives_n     = 2'd0;
                end
            end

            default: begin
                state_n     = ST_IDLE;
                frame_cnt_n = 16'd0;
                lives_n     = LIVES_INIT;
                score_n     = 8'd0;
            end
        endcase

        // Outputs follow the next state so they change together with it.
        case (state_n)
            ST_PLAY: begin
                game_stop_n = 1'b0;
                en_n        = 1'b1;
            end
            ST_OVER: begin
`ifdef AVOID_PAUSE_EN
                if (paused_n) begin
                    game_stop_n = 1'b0;
                end else begin
                    game_stop_n = 1'b1;
                end
`else
                game_stop_n = 1'b1;
`endif
                en_n = 1'b0;
            end
            default: begin
                game_stop_n = 1'b1;
                en_n        = 1'b0;
            end
        endcase
    end

    // State, counters, button history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            frame_cnt_r <= 16'd0;
            lives_r     <= LIVES_INIT;
            score_r     <= 8'd0;
            hit_pulse_r <= 1'b0;
            game_stop_r <= 1'b1;
            en_r        <= 1'b0;
            key4_d_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            frame_cnt_r <= frame_cnt_n;
            lives_r     <= lives_n;
            score_r     <= score_n;
            hit_pulse_r <= hit_pulse_n;
            game_stop_r <= game_stop_n;
            en_r        <= en_n;
            key4_d_r    <= bus.key[4];
        end
    end

`ifdef AVOID_PAUSE_EN
    // Pause button history and paused flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key3_d_r <= 1'b0;
            paused_r <= 1'b0;
        end else begin
            key3_d_r <= bus.key[3];
            paused_r <= paused_n;
        end
    end
`endif

    assign bus.state     = state_r;
    assign bus.game_stop = game_stop_r;
    assign bus.en        = en_r;
    assign bus.lives     = lives_r;
    assign bus.score     = score_r;
    assign bus.hit_pulse = hit_pulse_r;

endmodule

// File: tb/tb_avoid_collision_ctrl.sv
// -----------------------------------------------------------------------------
// tb_avoid_collision_ctrl
// Scoreboard bench: stimulus pushes the hand-computed output snapshot it
// expects next; the monitor pops one entry every time the DUT outputs change.
// -----------------------------------------------------------------------------
module tb_avoid_collision_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [14:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    avoid_collision_ctrl_if bus();

    avoid_collision_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Snapshot packing: {state, game_stop, en, lives, score, hit_pulse}
    task automatic expect_snap(input string nm, input logic [1:0] st, input logic gs,
                               input logic e, input logic [1:0] lv, input logic [7:0] sc,
                               input logic hp);
        exp_q.push_back({st, gs, e, lv, sc, hp});
        name_q.push_back(nm);
    endtask

    task automatic set_boxes(input int bl, input int br, input int bt, input int bb,
                             input int pl, input int pr, input int pt, input int pb);
        bus.ball_x_l = 10'(bl);
        bus.ball_x_r = 10'(br);
        bus.ball_y_t = 10'(bt);
        bus.ball_y_b = 10'(bb);
        bus.ply_x_l  = 10'(pl);
        bus.ply_x_r  = 10'(pr);
        bus.ply_y_t  = 10'(pt);
        bus.ply_y_b  = 10'(pb);
    endtask

    // One frame: a single tick cycle followed by one ordinary pixel cycle.
    task automatic frame();
        bus.x = 10'd639;
        bus.y = 10'd479;
        @(posedge clk);
        #1;
        bus.x = 10'd0;
        bus.y = 10'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input int bit_idx);
        bus.key[bit_idx] = 1'b1;
        @(posedge clk);
        #1;
        bus.key[bit_idx] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every change of the output snapshot consumes one expectation.
    initial begin
        logic [14:0] prev;
        logic [14:0] cur;
        logic [14:0] exp_v;
        string       nm;
        prev = 'x;
        #2;
        forever begin
            @(negedge clk);
            cur = {bus.state, bus.game_stop, bus.en, bus.lives, bus.score, bus.hit_pulse};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got st=%0d gs=%0b en=%0b lives=%0d score=%0d hit=%0b, required no change",
                             cur[14:13], cur[12], cur[11], cur[10:9], cur[8:1], cur[0]);
                end else begin
                    exp_v = exp_q.pop_front();
                    nm    = name_q.pop_front();
                    if (cur !== exp_v) begin
                        errors++;
                        $display("FAIL %s: got st=%0d gs=%0b en=%0b lives=%0d score=%0d hit=%0b, required st=%0d gs=%0b en=%0b lives=%0d score=%0d hit=%0b",
                                 nm, cur[14:13], cur[12], cur[11], cur[10:9], cur[8:1], cur[0],
                                 exp_v[14:13], exp_v[12], exp_v[11], exp_v[10:9], exp_v[8:1], exp_v[0]);
                    end
                end
                prev = cur;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        bus.x   = 10'd0;
        bus.y   = 10'd0;
        bus.key = 5'd0;
        set_boxes(100, 119, 100, 119, 119, 140, 119, 140);

        // Reset values
        expect_snap("reset", 2'd0, 1'b1, 1'b0, 2'd3, 8'd0, 1'b0);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // IDLE ignores frame ticks with overlap and the pause key
        repeat (3) frame();
        press_key(3);

        // 1. Start
        set_boxes(100, 119, 100, 119, 120, 140, 50, 200);   // x edges adjacent, no contact
        expect_snap("start", 2'd1, 1'b0, 1'b1, 2'd3, 8'd0, 1'b0);
        press_key(4);

        // 2. 120 clean frames -> score 2
        for (int i = 1; i <= 120; i++) begin
            if (i % 60 == 0) expect_snap("score_step", 2'd1, 1'b0, 1'b1, 2'd3, 8'(i / 60), 1'b0);
            frame();
        end

        // 3. Corner contact (touching at 119) -> HIT, then 60 frames back to PLAY
        set_boxes(100, 119, 100, 119, 119, 140, 119, 140);
        expect_snap("hit1", 2'd2, 1'b1, 1'b0, 2'd2, 8'd2, 1'b1);
        expect_snap("hit1_end", 2'd2, 1'b1, 1'b0, 2'd2, 8'd2, 1'b0);
        frame();
        press_key(4);                                        // ignored in HIT
        for (int i = 1; i <= 60; i++) begin
            if (i == 60) expect_snap("hit1_leave", 2'd1, 1'b0, 1'b1, 2'd2, 8'd2, 1'b0);
            frame();
        end

        // 4. Remaining contacts -> OVER
        expect_snap("hit2", 2'd2, 1'b1, 1'b0, 2'd1, 8'd2, 1'b1);
        expect_snap("hit2_end", 2'd2, 1'b1, 1'b0, 2'd1, 8'd2, 1'b0);
        frame();
        for (int i = 1; i <= 60; i++) begin
            if (i == 60) expect_snap("hit2_leave", 2'd1, 1'b0, 1'b1, 2'd1, 8'd2, 1'b0);
            frame();
        end
        expect_snap("over", 2'd3, 1'b1, 1'b0, 2'd0, 8'd2, 1'b1);
        expect_snap("over_end", 2'd3, 1'b1, 1'b0, 2'd0, 8'd2, 1'b0);
        frame();
        repeat (5) frame();                                  // OVER holds

        // Start held for 10 clocks -> one restart
        expect_snap("restart", 2'd1, 1'b0, 1'b1, 2'd3, 8'd0, 1'b0);
        bus.key[4] = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.key[4] = 1'b0;

        // 5a. Contact on the scoring tick: lives drop, score unchanged
        set_boxes(100, 119, 100, 119, 50, 200, 120, 140);   // y edges adjacent, no contact
        repeat (59) frame();
        set_boxes(100, 119, 100, 119, 119, 140, 119, 140);
        expect_snap("hit_on_score_tick", 2'd2, 1'b1, 1'b0, 2'd2, 8'd0, 1'b1);
        expect_snap("hit_on_score_tick_end", 2'd2, 1'b1, 1'b0, 2'd2, 8'd0, 1'b0);
        frame();
        for (int i = 1; i <= 60; i++) begin
            if (i == 60) expect_snap("hit3_leave", 2'd1, 1'b0, 1'b1, 2'd2, 8'd0, 1'b0);
            frame();
        end

        // 5b. Score saturation at 255
        set_boxes(0, 9, 0, 9, 300, 320, 300, 320);
        for (int i = 1; i <= 16000; i++) begin
            if ((i % 60 == 0) && (i / 60 <= 255))
                expect_snap("score_sat", 2'd1, 1'b0, 1'b1, 2'd2, 8'(i / 60), 1'b0);
            frame();
        end

        // Mid-game reset takes effect before the next clock edge
        expect_snap("reset_mid_game", 2'd0, 1'b1, 1'b0, 2'd3, 8'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

`ifdef AVOID_PAUSE_EN
        // 6. Pause freezes contact and scoring, counter holds
        expect_snap("pause_start", 2'd1, 1'b0, 1'b1, 2'd3, 8'd0, 1'b0);
        press_key(4);
        repeat (30) frame();
        expect_snap("pause_enter", 2'd3, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0);
        press_key(3);
        set_boxes(100, 119, 100, 119, 119, 140, 119, 140);
        repeat (200) frame();
        press_key(4);                                        // ignored in PAUSE
        set_boxes(0, 9, 0, 9, 300, 320, 300, 320);
        expect_snap("pause_leave", 2'd1, 1'b0, 1'b1, 2'd3, 8'd0, 1'b0);
        press_key(3);
        for (int i = 1; i <= 30; i++) begin
            if (i == 30) expect_snap("pause_score", 2'd1, 1'b0, 1'b1, 2'd3, 8'd1, 1'b0);
            frame();
        end
        expect_snap("pause_again", 2'd3, 1'b0, 1'b0, 2'd3, 8'd1, 1'b0);
        press_key(3);
        expect_snap("reset_in_pause", 2'd0, 1'b1, 1'b0, 2'd3, 8'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
`endif

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d outstanding, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
